// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: initiator-side controller for a single-port synchronous SRAM macro.
// It takes read/write requests on a valid/ready channel and drives one registered
// memory command per accepted request. Read data returns in order through a small
// first-word-fall-through response FIFO. Credits are counted so that every issued
// read always has a FIFO slot when its data arrives.
// Optional feature macro: MEM_PORT_CTRL_INIT_EN. When defined, the controller zero-fills
// the whole memory after reset before it accepts any request.
module mem_port_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 10,
  parameter int RD_LAT    = 1,
  parameter int RSP_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic              mem_chip_en,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  // Outstanding counter must hold 0..RSP_DEPTH; FIFO pointers need at least one bit.
  localparam int OW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [OW-1:0] DEPTH_C  = OW'(RSP_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(RSP_DEPTH - 1);

  logic run;
  logic accept;
  logic rd_accept;
  logic push;
  logic pop;

  // Registered memory command
  logic              mem_chip_en_q, mem_chip_en_d;
  logic              mem_wr_en_q,   mem_wr_en_d;
  logic              mem_rd_en_q,   mem_rd_en_d;
  logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
  logic [DATA_W-1:0] mem_wr_data_q, mem_wr_data_d;

  // Read-return tracking: bit k is set when a read sampled by the macro
  // k edges ago is still on its way back; the top bit marks capture.
  logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;

  // Credits and response FIFO
  logic [OW-1:0]     out_q, out_d;
  logic [OW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] fifo_mem_q [RSP_DEPTH];

`ifdef MEM_PORT_CTRL_INIT_EN
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] init_addr_q, init_addr_d;

  // Zero-fill sweep: one address per cycle, then RUN for good; the counter
  // wraps back to 0 as the last address is issued and stays idle afterwards.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    if (state_q == ST_INIT) begin
      init_addr_d = init_addr_q + ADDR_W'(1);
      if (init_addr_q == LAST_ADDR) state_d = ST_RUN;
    end
  end

  // FSM and sweep address state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  assign run       = (state_q == ST_RUN);
  assign init_done = run;
`else
  // Without the sweep the controller is serviceable as soon as reset drops.
  assign run       = 1'b1;
  assign init_done = ~reset;
`endif

  // Gate on credits only; request type and valid do not affect readiness.
  assign req_ready = run && (out_q < DEPTH_C);
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_write;

  assign push      = rd_pipe_q[RD_LAT-1];
  assign rsp_valid = (cnt_q != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_rdata = fifo_mem_q[rd_ptr_q];

  // Next memory command: strobes last exactly one cycle, address/data hold otherwise.
  always_comb begin
    mem_chip_en_d = 1'b0;
    mem_wr_en_d   = 1'b0;
    mem_rd_en_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
`ifdef MEM_PORT_CTRL_INIT_EN
    if (state_q == ST_INIT) begin
      mem_chip_en_d = 1'b1;
      mem_wr_en_d   = 1'b1;
      mem_addr_d    = init_addr_q;
      mem_wr_data_d = '0;
    end else
`endif
    if (accept) begin
      mem_chip_en_d = 1'b1;
      mem_wr_en_d   = req_write;
      mem_rd_en_d   = !req_write;
      mem_addr_d    = req_addr;
      mem_wr_data_d = req_wdata;
    end
  end

  // Shift read markers toward the capture point; the live read strobe enters at bit 0
  // because the macro samples it on the edge that ends the command cycle.
  always_comb begin
    rd_pipe_d = RD_LAT'({rd_pipe_q, mem_rd_en_q});
  end

  // Credit and FIFO bookkeeping: a read accept takes a credit, a pop returns it.
  always_comb begin
    out_d    = out_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    case ({rd_accept, pop})
      2'b10:   out_d = out_q + OW'(1);
      2'b01:   out_d = out_q - OW'(1);
      default: out_d = out_q;
    endcase
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + OW'(1);
      2'b01:   cnt_d = cnt_q - OW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
  end

  // Control state; reset drops every in-flight read and buffered response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_chip_en_q <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      rd_pipe_q     <= '0;
      out_q         <= '0;
      cnt_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      mem_chip_en_q <= mem_chip_en_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      rd_pipe_q     <= rd_pipe_d;
      out_q         <= out_d;
      cnt_q         <= cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // FIFO storage needs no reset: the occupancy count qualifies every entry.
  always_ff @(posedge clock) begin
    if (push) fifo_mem_q[wr_ptr_q] <= mem_rd_data;
  end

  assign mem_chip_en = mem_chip_en_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb_mem_port_ctrl: self-checking bench for mem_port_ctrl with a behavioural SRAM macro
// and a reference memory/response-queue model. Build with MEM_PORT_CTRL_INIT_EN defined
// to exercise the zero-fill sweep on a 16-word memory.
module tb_mem_port_ctrl;
  localparam int DATA_W = 16;
`ifdef MEM_PORT_CTRL_INIT_EN
  localparam int ADDR_W = 4;
`else
  localparam int ADDR_W = 10;
`endif
  localparam int RD_LAT    = 1;
  localparam int RSP_DEPTH = 2;
  localparam int NWORDS    = 1 << ADDR_W;

  logic              clock, reset;
  logic              req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid, rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              init_done;
  logic              mem_chip_en, mem_wr_en, mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data, mem_rd_data;

  int errors = 0;
  int checks = 0;

  mem_port_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .mem_chip_en(mem_chip_en), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DATA_W-1:0] init_val(int i);
    return DATA_W'(i * 40503 + 12345);
  endfunction

  // Behavioural SRAM macro: command seen mid-cycle, acted on at the next edge,
  // read data appears RD_LAT edges after the sampling edge.
  logic [DATA_W-1:0] mem_model [NWORDS];
  initial begin
    logic              c_en, c_wr, c_rd;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_data;
    logic [DATA_W-1:0] lat_q [$];
    for (int i = 0; i < NWORDS; i++) mem_model[i] = init_val(i);
    for (int i = 0; i < RD_LAT - 1; i++) lat_q.push_back('0);
    mem_rd_data <= '0;
    forever begin
      @(negedge clock);
      c_en = mem_chip_en; c_wr = mem_wr_en; c_rd = mem_rd_en;
      c_addr = mem_addr; c_data = mem_wr_data;
      @(posedge clock);
      lat_q.push_back((c_en && c_rd) ? mem_model[c_addr] : mem_rd_data);
      if (c_en && c_wr) mem_model[c_addr] = c_data;
      mem_rd_data <= lat_q.pop_front();
    end
  end

  // Reference model and observation: expected read data computed at accept time
  // from a plain array, observed responses collected on each pop.
  logic [DATA_W-1:0] ref_mem [NWORDS];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] got_q [$];
  bit                rd_hist [$];
  int n_chip = 0, n_rd = 0, n_rspv = 0;
  initial begin
    for (int i = 0; i < NWORDS; i++) begin
`ifdef MEM_PORT_CTRL_INIT_EN
      ref_mem[i] = '0;
`else
      ref_mem[i] = init_val(i);
`endif
    end
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_q.delete();
        got_q.delete();
      end else begin
        if (mem_chip_en) n_chip++;
        if (mem_rd_en) n_rd++;
        if (rsp_valid) n_rspv++;
        rd_hist.push_back(mem_rd_en);
        if (rsp_valid && rsp_ready) got_q.push_back(rsp_rdata);
        if (req_valid && req_ready) begin
          if (req_write) ref_mem[req_addr] = req_wdata;
          else exp_q.push_back(ref_mem[req_addr]);
        end
      end
    end
  end

  // Present a request and hold it until the DUT is ready; returns at the
  // mid-cycle point just before the accepting edge.
  task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       output bit ok);
    @(posedge clock); #1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (req_ready) begin ok = 1'b1; break; end
    end
  endtask

  task automatic idle();
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks++;
    if ({mem_chip_en, mem_wr_en, mem_rd_en} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes: got %b want 000", {mem_chip_en, mem_wr_en, mem_rd_en});
    end
    checks++;
    if (mem_addr !== '0 || mem_wr_data !== '0) begin
      errors++; $display("FAIL reset_addr_data: got %h/%h want 0/0", mem_addr, mem_wr_data);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++;
    if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b want 0", init_done); end
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
`ifdef MEM_PORT_CTRL_INIT_EN
    checks++;
    if (init_done !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL release_init: got done=%b ready=%b want 0/0", init_done, req_ready);
    end
`else
    checks++;
    if (init_done !== 1'b1) begin errors++; $display("FAIL release_init_done: got %b want 1", init_done); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", req_ready); end
`endif
  endtask

`ifdef MEM_PORT_CTRL_INIT_EN
  task automatic test_init();
    int seen = 0, bad = 0, c0, gb;
    bit reached = 1'b0, ok;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (mem_chip_en) begin
        if (!(mem_wr_en && !mem_rd_en && mem_addr == ADDR_W'(seen) && mem_wr_data == '0)) bad++;
        seen++;
      end
      if (req_ready && !init_done) bad++;
      if (init_done) begin reached = 1'b1; break; end
    end
    checks++;
    if (!reached) begin errors++; $display("FAIL init_timeout: init_done never rose"); end
    checks++;
    if (seen != NWORDS) begin errors++; $display("FAIL init_count: got %0d writes want %0d", seen, NWORDS); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL init_sweep: %0d bad sweep cycles want 0", bad); end
    c0 = n_chip;
    repeat (3) @(negedge clock);
    checks++;
    if (n_chip != c0) begin errors++; $display("FAIL init_after: got %0d extra commands want 0", n_chip - c0); end
    rsp_ready = 1'b1;
    gb = got_q.size();
    issue(1'b0, ADDR_W'(7), '0, ok);
    idle();
    repeat (6) @(negedge clock);
    checks++;
    if (!ok || got_q.size() != gb + 1 || got_q[gb] !== 16'h0000) begin
      errors++; $display("FAIL init_read7: ok=%0d n=%0d data=%h want 1/1/0000", ok, got_q.size() - gb,
                         (got_q.size() > gb) ? got_q[gb] : 16'hxxxx);
    end
  endtask
`endif

  task automatic test_write_read();
    int c0, gb, lat = -1;
    bit ok1, ok2;
    logic [ADDR_W-1:0] a;
    a = ADDR_W'(10'h3FF);
    rsp_ready = 1'b1;
    repeat (3) @(negedge clock);
    c0 = n_chip; gb = got_q.size();
    issue(1'b1, a, 16'hA5C3, ok1);
    issue(1'b0, a, 16'h0000, ok2);
    idle();
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (rsp_valid) begin lat = k - 1; break; end
    end
    checks++;
    if (!(ok1 && ok2)) begin errors++; $display("FAIL wr_rd_accept: got %0d%0d want 11", ok1, ok2); end
    checks++;
    if (lat != RD_LAT + 1) begin errors++; $display("FAIL wr_rd_latency: got %0d want %0d", lat, RD_LAT + 1); end
    repeat (4) @(negedge clock);
    checks++;
    if (n_chip - c0 != 2) begin errors++; $display("FAIL wr_rd_chip_en: got %0d cycles want 2", n_chip - c0); end
    checks++;
    if (got_q.size() != gb + 1 || got_q[gb] !== 16'hA5C3) begin
      errors++; $display("FAIL wr_rd_data: n=%0d data=%h want 1/a5c3", got_q.size() - gb,
                         (got_q.size() > gb) ? got_q[gb] : 16'hxxxx);
    end
  endtask

  task automatic test_backpressure();
    logic [ADDR_W-1:0] a [3];
    int gb, eb, busy = 0, at_accept = -1, mism = 0;
    bit ok, okall = 1'b1;
    a[0] = ADDR_W'($urandom_range(0, NWORDS - 1));
    a[1] = a[0] ^ ADDR_W'(1);
    a[2] = a[0] ^ ADDR_W'(2);
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, a[i], DATA_W'(16'h1100 + i * 16'h0111), ok);
      if (!ok) okall = 1'b0;
    end
    idle();
    @(posedge clock); #1 rsp_ready = 1'b0;
    gb = got_q.size(); eb = exp_q.size();
    issue(1'b0, a[0], '0, ok); if (!ok) okall = 1'b0;
    issue(1'b0, a[1], '0, ok); if (!ok) okall = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = a[2];
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (req_ready !== 1'b0) busy++;
    end
    checks++;
    if (!okall) begin errors++; $display("FAIL bp_accept: first accepts timed out"); end
    checks++;
    if (busy != 0) begin errors++; $display("FAIL bp_ready_low: ready high %0d cycles want 0", busy); end
    checks++;
    if (rsp_valid !== 1'b1 || got_q.size() != gb) begin
      errors++; $display("FAIL bp_hold: valid=%b popped=%0d want 1/0", rsp_valid, got_q.size() - gb);
    end
    @(posedge clock); #1 rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (req_ready) begin at_accept = got_q.size() - gb; break; end
    end
    idle();
    repeat (6) @(negedge clock);
    checks++;
    if (at_accept < 1) begin errors++; $display("FAIL bp_third: got %0d returned before accept want >=1", at_accept); end
    for (int i = 0; i < 3; i++)
      if (got_q.size() <= gb + i || exp_q.size() <= eb + i || got_q[gb + i] !== exp_q[eb + i]) mism++;
    checks++;
    if (mism != 0 || got_q.size() != gb + 3) begin
      errors++; $display("FAIL bp_order: %0d mismatches, %0d responses want 0/3", mism, got_q.size() - gb);
    end
  endtask

  task automatic test_stream();
    int hb, gb, eb, ones = 0, mr = 0, r = 0, mism = 0;
    bit ok, okall = 1'b1;
    rsp_ready = 1'b1;
    hb = rd_hist.size(); gb = got_q.size(); eb = exp_q.size();
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, ADDR_W'(i), '0, ok);
      if (!ok) okall = 1'b0;
    end
    idle();
    repeat (8) @(negedge clock);
    for (int i = hb; i < rd_hist.size(); i++) begin
      if (rd_hist[i]) begin ones++; r++; if (r > mr) mr = r; end
      else r = 0;
    end
    checks++;
    if (!okall || ones != 8) begin errors++; $display("FAIL stream_rd_en: ok=%0d got %0d cycles want 8", okall, ones); end
    checks++;
    if (mr < 2) begin errors++; $display("FAIL stream_b2b: longest run %0d want >=2", mr); end
    for (int i = 0; i < 8; i++)
      if (got_q.size() <= gb + i || exp_q.size() <= eb + i || got_q[gb + i] !== exp_q[eb + i]) mism++;
    checks++;
    if (mism != 0 || got_q.size() != gb + 8) begin
      errors++; $display("FAIL stream_order: %0d mismatches, %0d responses want 0/8", mism, got_q.size() - gb);
    end
  endtask

  task automatic test_simultaneous();
    int gb, eb;
    bit ok, okall = 1'b1;
    rsp_ready = 1'b1;
    issue(1'b1, ADDR_W'(3), 16'hBEEF, ok); if (!ok) okall = 1'b0;
    issue(1'b1, ADDR_W'(5), 16'hCAFE, ok); if (!ok) okall = 1'b0;
    idle();
    @(posedge clock); #1 rsp_ready = 1'b0;
    gb = got_q.size(); eb = exp_q.size();
    issue(1'b0, ADDR_W'(3), '0, ok); if (!ok) okall = 1'b0;
    issue(1'b0, ADDR_W'(5), '0, ok); if (!ok) okall = 1'b0;
    idle();
    repeat (RD_LAT) @(posedge clock);
    #1 rsp_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (!okall || rsp_valid !== 1'b1 || rsp_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL simul_head: ok=%0d valid=%b data=%h want 1/1/beef", okall, rsp_valid, rsp_rdata);
    end
    @(posedge clock); #1 rsp_ready = 1'b0;
    @(negedge clock);
    checks++;
    if (rsp_valid !== 1'b1 || got_q.size() != gb + 1 || rsp_rdata !== exp_q[eb + 1]) begin
      errors++; $display("FAIL simul_occupancy: valid=%b popped=%0d data=%h want 1/1/%h",
                         rsp_valid, got_q.size() - gb, rsp_rdata, exp_q[eb + 1]);
    end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL simul_credit: ready=%b want 1", req_ready); end
    @(posedge clock); #1 rsp_ready = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (got_q.size() != gb + 2 || got_q[gb] !== exp_q[eb] || got_q[gb + 1] !== 16'hCAFE) begin
      errors++; $display("FAIL simul_order: n=%0d want 2 with beef,cafe", got_q.size() - gb);
    end
  endtask

  task automatic test_random();
    int gb, eb, mism = 0;
    bit done = 1'b0, okall = 1'b1;
    gb = got_q.size(); eb = exp_q.size();
    fork
      begin
        bit ok;
        for (int n = 0; n < 150; n++) begin
          issue($urandom_range(0, 2) == 0, ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom), ok);
          if (!ok) okall = 1'b0;
        end
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clock); #1 rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge clock); #1 rsp_ready = 1'b1;
    repeat (10) @(negedge clock);
    for (int i = 0; i < exp_q.size() - eb; i++)
      if (got_q.size() <= gb + i || got_q[gb + i] !== exp_q[eb + i]) mism++;
    checks++;
    if (!okall) begin errors++; $display("FAIL random_accept: a request timed out"); end
    checks++;
    if (mism != 0 || got_q.size() - gb != exp_q.size() - eb) begin
      errors++; $display("FAIL random_scoreboard: %0d mismatches, got %0d responses want %0d",
                         mism, got_q.size() - gb, exp_q.size() - eb);
    end
  endtask

  task automatic test_reset_mid();
    int v0, r0;
    bit ok1, ok2, reached = 1'b0;
    rsp_ready = 1'b0;
    issue(1'b0, ADDR_W'(1), '0, ok1);
    issue(1'b0, ADDR_W'(2), '0, ok2);
    idle();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (!(ok1 && ok2) || {mem_chip_en, mem_wr_en, mem_rd_en} !== 3'b000 || mem_addr !== '0) begin
      errors++; $display("FAIL midreset_mem: ok=%0d%0d strobes=%b addr=%h want 11/000/0",
                         ok1, ok2, {mem_chip_en, mem_wr_en, mem_rd_en}, mem_addr);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midreset_rsp_valid: got %b want 0", rsp_valid); end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    v0 = n_rspv; r0 = n_rd;
    rsp_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (init_done) begin reached = 1'b1; break; end
    end
    repeat (10) @(negedge clock);
    checks++;
    if (!reached) begin errors++; $display("FAIL midreset_init: init_done never rose"); end
    checks++;
    if (n_rspv != v0 || got_q.size() != 0 || n_rd != r0) begin
      errors++; $display("FAIL midreset_ghost: valid=%0d responses=%0d reads=%0d want 0/0/0",
                         n_rspv - v0, got_q.size(), n_rd - r0);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    test_reset();
`ifdef MEM_PORT_CTRL_INIT_EN
    test_init();
`endif
    test_write_read();
    test_backpressure();
    test_stream();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
